// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the byte-banked data memory between the CPU MEM stage and the debug unit
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [31:0]           i_cpu_wdata,
    input  logic [1:0]            i_cpu_size,
    input  logic                  i_cpu_wen,
    input  logic                  i_cpu_ren,
    output logic [31:0]           o_cpu_rdata,
    output logic                  o_cpu_stall,
    input  logic                  i_dbg_req,
    input  logic                  i_dbg_we,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [31:0]           i_dbg_wdata,
    input  logic [1:0]            i_dbg_size,
    output logic                  o_dbg_gnt,
    output logic                  o_dbg_rvalid,
    output logic [31:0]           o_dbg_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    output logic [31:0]           o_mem_din,
    output logic [1:0]            o_mem_size,
    output logic                  o_mem_wen,
    output logic                  o_mem_ren,
    input  logic [31:0]           i_mem_dout
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, DBG_ACC, DBG_RSP} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          cpu_busy;

    assign cpu_busy = i_cpu_wen | i_cpu_ren;

    // Arbitration FSM: debug wins when the CPU is idle or has starved it for STARVE_LIMIT cycles
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            o_dbg_rvalid <= 1'b0;
            o_dbg_rdata  <= '0;
        end else begin
            o_dbg_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_dbg_req && (!cpu_busy || starve_cnt == LIMIT)) begin
                        state      <= DBG_ACC;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= !i_dbg_req ? '0 :
                                      starve_cnt == LIMIT ? starve_cnt : starve_cnt + CW'(1);
                    end
                end
                DBG_ACC: state <= i_dbg_we ? IDLE : DBG_RSP;
                DBG_RSP: begin
                    o_dbg_rdata  <= i_mem_dout;
                    o_dbg_rvalid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port steering; raddr stays on the debug address through DBG_RSP for lane rotation
    always_comb begin
        o_cpu_stall = state != IDLE;
        o_dbg_gnt   = state == DBG_ACC;
        o_cpu_rdata = o_cpu_stall ? '0 : i_mem_dout;
        o_mem_waddr = o_cpu_stall ? i_dbg_addr : i_cpu_addr;
        o_mem_raddr = o_cpu_stall ? i_dbg_addr : i_cpu_addr;
        o_mem_din   = o_cpu_stall ? i_dbg_wdata : i_cpu_wdata;
        o_mem_size  = o_cpu_stall ? i_dbg_size : i_cpu_size;
        o_mem_wen   = o_cpu_stall ? o_dbg_gnt & i_dbg_we : i_cpu_wen;
        o_mem_ren   = o_cpu_stall ? o_dbg_gnt & ~i_dbg_we : i_cpu_ren;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of the debug/CPU memory port arbiter
module tb_dmem_port_arbiter;
    localparam int AW = 10;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [AW-1:0] i_cpu_addr = '0;
    logic [31:0]   i_cpu_wdata = '0;
    logic [1:0]    i_cpu_size = '0;
    logic          i_cpu_wen = 1'b0;
    logic          i_cpu_ren = 1'b0;
    logic [31:0]   o_cpu_rdata;
    logic          o_cpu_stall;
    logic          i_dbg_req = 1'b0;
    logic          i_dbg_we = 1'b0;
    logic [AW-1:0] i_dbg_addr = '0;
    logic [31:0]   i_dbg_wdata = '0;
    logic [1:0]    i_dbg_size = '0;
    logic          o_dbg_gnt;
    logic          o_dbg_rvalid;
    logic [31:0]   o_dbg_rdata;
    logic [AW-1:0] o_mem_waddr;
    logic [AW-1:0] o_mem_raddr;
    logic [31:0]   o_mem_din;
    logic [1:0]    o_mem_size;
    logic          o_mem_wen;
    logic          o_mem_ren;
    logic [31:0]   i_mem_dout;

    int pass_cnt = 0;
    int total_cnt = 0;
    int pcnt = 0;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata), .i_cpu_size(i_cpu_size),
        .i_cpu_wen(i_cpu_wen), .i_cpu_ren(i_cpu_ren), .o_cpu_rdata(o_cpu_rdata),
        .o_cpu_stall(o_cpu_stall), .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we),
        .i_dbg_addr(i_dbg_addr), .i_dbg_wdata(i_dbg_wdata), .i_dbg_size(i_dbg_size),
        .o_dbg_gnt(o_dbg_gnt), .o_dbg_rvalid(o_dbg_rvalid), .o_dbg_rdata(o_dbg_rdata),
        .o_mem_waddr(o_mem_waddr), .o_mem_raddr(o_mem_raddr), .o_mem_din(o_mem_din),
        .o_mem_size(o_mem_size), .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren),
        .i_mem_dout(i_mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Byte-banked memory: 4 lanes per row, sync read, output rotated by the live read address
    logic [7:0]  mem [0:(1<<AW)-1];
    logic [31:0] rd_row;
    logic        rd_valid;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[{a[AW-1:2], a[1:0] + 2'(i)}];
        return w;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return s == 2'd1 ? 1 : s == 2'd2 ? 2 : s == 2'd3 ? 4 : 0;
    endfunction

    always @(posedge clk) begin
        rd_valid <= o_mem_ren;
        for (int i = 0; i < 4; i++) rd_row[8*i +: 8] <= mem[{o_mem_raddr[AW-1:2], 2'(i)}];
        if (o_mem_wen)
            for (int i = 0; i < nbytes(o_mem_size); i++)
                mem[{o_mem_waddr[AW-1:2], o_mem_waddr[1:0] + 2'(i)}] <= o_mem_din[8*i +: 8];
    end

    logic [63:0] rot;
    always_comb begin
        rot = {rd_row, rd_row} >> (8 * o_mem_raddr[1:0]);
        i_mem_dout = rd_valid ? rot[31:0] : 32'h0;
    end

    // Reference model: a schedule of which cycles debug owns the port, when gnt/rvalid fire
    int          cyc = 0;
    int          own_end = -1;
    int          gnt_at = -1;
    int          rv_at = -1;
    int          waited = 0;
    logic [31:0] exp_rd = '0;
    logic [31:0] hold_rd = '0;
    logic        owned;

    always @(negedge clk) begin
        cyc++;
        if (!i_rst_n) begin
            chk("rst_stall", o_cpu_stall, 0);
            chk("rst_gnt", o_dbg_gnt, 0);
            chk("rst_rvalid", o_dbg_rvalid, 0);
            chk("rst_rdata", o_dbg_rdata, 0);
            own_end = -1; gnt_at = -1; rv_at = -1; waited = 0; hold_rd = '0;
        end else begin
            owned = cyc <= own_end;
            if (cyc == gnt_at && !i_dbg_we) exp_rd = mem_word(i_dbg_addr);
            if (cyc == rv_at) hold_rd = exp_rd;
            chk("stall", o_cpu_stall, owned);
            chk("gnt", o_dbg_gnt, cyc == gnt_at);
            chk("rvalid", o_dbg_rvalid, cyc == rv_at);
            chk("rdata", o_dbg_rdata, hold_rd);
            chk("cpu_rdata", o_cpu_rdata, owned ? 32'h0 : i_mem_dout);
            if (!owned)
                chk("mem_cpu", {o_mem_waddr, o_mem_raddr, o_mem_din, o_mem_size, o_mem_wen, o_mem_ren},
                    {i_cpu_addr, i_cpu_addr, i_cpu_wdata, i_cpu_size, i_cpu_wen, i_cpu_ren});
            else if (cyc == gnt_at)
                chk("mem_dbg", {o_mem_waddr, o_mem_raddr, o_mem_din, o_mem_size, o_mem_wen, o_mem_ren},
                    {i_dbg_addr, i_dbg_addr, i_dbg_wdata, i_dbg_size, i_dbg_we, !i_dbg_we});
            else
                chk("mem_rsp", {o_mem_raddr, o_mem_wen, o_mem_ren}, {i_dbg_addr, 2'b00});
            if (!owned) begin
                if (i_dbg_req && (!(i_cpu_wen || i_cpu_ren) || waited == LIMIT)) begin
                    gnt_at  = cyc + 1;
                    own_end = cyc + (i_dbg_we ? 1 : 2);
                    rv_at   = i_dbg_we ? -1 : cyc + 3;
                    waited  = 0;
                end else begin
                    waited = !i_dbg_req ? 0 : waited < LIMIT ? waited + 1 : waited;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        @(negedge clk);
        while (!o_dbg_gnt && n < 50) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!o_dbg_gnt) chk("gnt_timeout", 0, 1);
    endtask

    int n;
    int g [3];
    logic got = 1'b0;
    logic stalled = 1'b0;
    int hold_off = 0;

    initial begin
        repeat (3) tick();
        i_rst_n = 1'b1;
        // CPU store then load, no debug traffic
        i_cpu_wen = 1; i_cpu_size = 2'd3; i_cpu_addr = 10'h08; i_cpu_wdata = 32'hDEADBEEF;
        tick();
        i_cpu_wen = 0; i_cpu_ren = 1;
        tick();
        i_cpu_ren = 0;
        @(negedge clk);
        chk("t1_lw", o_cpu_rdata, 32'hDEADBEEF);
        chk("t1_stall", o_cpu_stall, 0);
        tick();
        // Debug word write while CPU idle, then CPU reads it back
        i_dbg_we = 1; i_dbg_addr = 10'h0C; i_dbg_wdata = 32'h12345678; i_dbg_size = 2'd3; i_dbg_req = 1;
        wait_gnt(n);
        chk("t2_gnt_lat", n, 1);
        tick();
        i_dbg_req = 0; i_cpu_ren = 1; i_cpu_addr = 10'h0C;
        tick();
        i_cpu_ren = 0;
        @(negedge clk);
        chk("t2_lw", o_cpu_rdata, 32'h12345678);
        tick();
        // Debug half read at an odd address
        i_cpu_wen = 1; i_cpu_size = 2'd3; i_cpu_addr = 10'h04; i_cpu_wdata = 32'hAABBCCDD;
        tick();
        i_cpu_wen = 0; i_dbg_we = 0; i_dbg_addr = 10'h05; i_dbg_size = 2'd2; i_dbg_req = 1;
        wait_gnt(n);
        tick();
        i_dbg_req = 0;
        @(negedge clk);
        chk("t3_rsp_rvalid", o_dbg_rvalid, 0);
        chk("t3_rsp_stall", o_cpu_stall, 1);
        tick();
        @(negedge clk);
        chk("t3_rvalid", o_dbg_rvalid, 1);
        chk("t3_rdata", o_dbg_rdata[15:0], 16'hBBCC);
        chk("t3_stall", o_cpu_stall, 0);
        tick();
        // Starvation: CPU loads every cycle
        i_cpu_ren = 1; i_cpu_addr = 10'h20; i_dbg_we = 0; i_dbg_addr = 10'h10; i_dbg_size = 2'd3; i_dbg_req = 1;
        wait_gnt(n);
        chk("t4_read_lat", n, LIMIT + 1);
        chk("t4_stall_gnt", o_cpu_stall, 1);
        tick();
        i_dbg_req = 0;
        @(negedge clk);
        chk("t4_stall_rsp", o_cpu_stall, 1);
        tick();
        @(negedge clk);
        chk("t4_stall_after", o_cpu_stall, 0);
        tick();
        i_dbg_we = 1; i_dbg_wdata = 32'h0BADF00D; i_dbg_req = 1;
        wait_gnt(n);
        chk("t4_write_lat", n, LIMIT + 1);
        tick();
        i_dbg_req = 0;
        @(negedge clk);
        chk("t4_write_stall_after", o_cpu_stall, 0);
        tick();
        i_cpu_ren = 0;
        // Reset during the read response
        i_dbg_we = 0; i_dbg_addr = 10'h0C; i_dbg_req = 1;
        wait_gnt(n);
        tick();
        i_dbg_req = 0;
        #2 i_rst_n = 0;
        @(negedge clk);
        chk("t5_stall", o_cpu_stall, 0);
        chk("t5_rvalid", o_dbg_rvalid, 0);
        chk("t5_rdata", o_dbg_rdata, 0);
        tick();
        @(negedge clk);
        chk("t5_rvalid_after", o_dbg_rvalid, 0);
        tick();
        i_rst_n = 1;
        tick();
        // Held debug read request with CPU idle
        i_dbg_we = 0; i_dbg_addr = 10'h04; i_dbg_size = 2'd3; i_dbg_req = 1;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(n);
            g[k] = pcnt;
            tick();
        end
        i_dbg_req = 0;
        chk("t6_gap1", g[1] - g[0], 3);
        chk("t6_gap2", g[2] - g[1], 3);
        repeat (2) tick();
        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if (!stalled) begin
                i_cpu_wen = 1'($urandom_range(0, 1));
                i_cpu_ren = 1'($urandom_range(0, 1));
                i_cpu_addr = AW'($urandom_range(0, 63));
                i_cpu_size = 2'($urandom_range(0, 3));
                i_cpu_wdata = $urandom;
            end
            if (i_dbg_req && got) begin
                i_dbg_req = 0;
                hold_off = 2;
            end else if (hold_off > 0) begin
                hold_off--;
            end else if (!i_dbg_req && $urandom_range(0, 2) == 0) begin
                i_dbg_we = 1'($urandom_range(0, 1));
                i_dbg_addr = AW'($urandom_range(0, 63));
                i_dbg_size = 2'($urandom_range(0, 3));
                i_dbg_wdata = $urandom;
                i_dbg_req = 1;
            end
            @(negedge clk);
            got = o_dbg_gnt;
            stalled = o_cpu_stall;
            tick();
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
